// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle controller: control-field codes, opcodes/functs,
// FSM states and decoded instruction classes.
package mc_ctrl_fsm_pkg;

   localparam int OP_W    = 6;
   localparam int FUNCT_W = 6;
   localparam int STATE_W = 3;
   localparam int EXTOP_W = 2;
   localparam int ALUOP_W = 3;
   localparam int NPCOP_W = 2;
   localparam int WDSEL_W = 1;

   localparam logic [EXTOP_W-1:0] EXT_SIGNED = 2'd0;
   localparam logic [EXTOP_W-1:0] EXT_UNSIGN = 2'd1;
   localparam logic [EXTOP_W-1:0] EXT_HIGH16 = 2'd2;

   localparam logic [ALUOP_W-1:0] ALU_ADD = 3'd0;
   localparam logic [ALUOP_W-1:0] ALU_SUB = 3'd1;
   localparam logic [ALUOP_W-1:0] ALU_AND = 3'd2;
   localparam logic [ALUOP_W-1:0] ALU_OR  = 3'd3;
   localparam logic [ALUOP_W-1:0] ALU_SLT = 3'd4;
   localparam logic [ALUOP_W-1:0] ALU_LUI = 3'd5;

   localparam logic [NPCOP_W-1:0] NPC_PLUS4  = 2'd0;
   localparam logic [NPCOP_W-1:0] NPC_BRANCH = 2'd1;
   localparam logic [NPCOP_W-1:0] NPC_JUMP   = 2'd2;

   localparam logic [WDSEL_W-1:0] WD_ALU = 1'b0;
   localparam logic [WDSEL_W-1:0] WD_MEM = 1'b1;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
   localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
   localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

   localparam logic [FUNCT_W-1:0] FN_ADD  = 6'h20;
   localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;
   localparam logic [FUNCT_W-1:0] FN_SUB  = 6'h22;
   localparam logic [FUNCT_W-1:0] FN_SUBU = 6'h23;
   localparam logic [FUNCT_W-1:0] FN_AND  = 6'h24;
   localparam logic [FUNCT_W-1:0] FN_OR   = 6'h25;
   localparam logic [FUNCT_W-1:0] FN_SLT  = 6'h2A;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH = 3'd0,
      S_DCD   = 3'd1,
      S_EXE   = 3'd2,
      S_MEM   = 3'd3,
      S_WB    = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      C_RTYPE = 3'd0,
      C_ALUI  = 3'd1,
      C_LW    = 3'd2,
      C_SW    = 3'd3,
      C_BEQ   = 3'd4,
      C_J     = 3'd5,
      C_ILL   = 3'd6
   } iclass_t;

endpackage

// File: rtl/mc_ctrl_fsm_instr_decode.sv
// Combinational instruction decoder: Op/Funct to instruction class, extender mode,
// ALU operation and illegal flag.
module mc_ctrl_fsm_instr_decode
   import mc_ctrl_fsm_pkg::*;
(
   input  logic [OP_W-1:0]    Op,
   input  logic [FUNCT_W-1:0] Funct,
   output iclass_t            dec_class,
   output logic [EXTOP_W-1:0] dec_ext,
   output logic [ALUOP_W-1:0] dec_alu,
   output logic               dec_illegal
);

   // Opcode and function-field decode
   always_comb begin
      dec_class = C_ILL;
      dec_ext   = EXT_SIGNED;
      dec_alu   = ALU_ADD;
      case (Op)
         OP_RTYPE: begin
            dec_class = C_RTYPE;
            case (Funct)
               FN_ADD, FN_ADDU: dec_alu = ALU_ADD;
               FN_SUB, FN_SUBU: dec_alu = ALU_SUB;
               FN_AND:          dec_alu = ALU_AND;
               FN_OR:           dec_alu = ALU_OR;
               FN_SLT:          dec_alu = ALU_SLT;
               default:         dec_class = C_ILL;
            endcase
         end
         OP_J:     dec_class = C_J;
         OP_BEQ: begin
            dec_class = C_BEQ;
            dec_alu   = ALU_SUB;
         end
         OP_ADDIU: dec_class = C_ALUI;
         OP_ORI: begin
            dec_class = C_ALUI;
            dec_ext   = EXT_UNSIGN;
            dec_alu   = ALU_OR;
         end
         OP_LUI: begin
            dec_class = C_ALUI;
            dec_ext   = EXT_HIGH16;
            dec_alu   = ALU_LUI;
         end
         OP_LW:    dec_class = C_LW;
         OP_SW:    dec_class = C_SW;
         default:  dec_class = C_ILL;
      endcase
      dec_illegal = (dec_class == C_ILL);
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM: FETCH/DCD/EXE/MEM/WB sequencing with a req/ack memory stall.
// Decode fields are latched in DCD; a synchronous reset masks every pulse in its cycle.
module mc_ctrl_fsm
   import mc_ctrl_fsm_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [OP_W-1:0]    Op,
   input  logic [FUNCT_W-1:0] Funct,
   input  logic               Zero,
   input  logic               mem_ack,
   output logic               mem_req,
   output logic               DMWr,
   output logic               IRWr,
   output logic               PCWr,
   output logic [NPCOP_W-1:0] NPCOp,
   output logic               RFWr,
   output logic [WDSEL_W-1:0] WDSel,
   output logic [EXTOP_W-1:0] ExtOp,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               illegal
);

   state_t               state_r, state_nxt_s;
   iclass_t              class_r, dec_class_s;
   logic [EXTOP_W-1:0]   ext_r, dec_ext_s;
   logic [ALUOP_W-1:0]   alu_r, dec_alu_s;
   logic                 dec_illegal_s;
   logic                 mem_req_s, dmwr_s, irwr_s, pcwr_s, rfwr_s, illegal_s;
   logic [NPCOP_W-1:0]   npc_s;
   logic [WDSEL_W-1:0]   wdsel_s;

   mc_ctrl_fsm_instr_decode u_decode (
      .Op          (Op),
      .Funct       (Funct),
      .dec_class   (dec_class_s),
      .dec_ext     (dec_ext_s),
      .dec_alu     (dec_alu_s),
      .dec_illegal (dec_illegal_s)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Decode fields captured in DCD and held until the next DCD
   always_ff @(posedge clk) begin
      if (rst) begin
         class_r <= C_RTYPE;
         ext_r   <= EXT_SIGNED;
         alu_r   <= ALU_ADD;
      end else if (state_r == S_DCD) begin
         class_r <= dec_class_s;
         ext_r   <= dec_ext_s;
         alu_r   <= dec_alu_s;
      end else begin
         class_r <= class_r;
         ext_r   <= ext_r;
         alu_r   <= alu_r;
      end
   end

   // Next-state and control decode
   always_comb begin
      state_nxt_s = S_FETCH;
      mem_req_s   = 1'b0;
      dmwr_s      = 1'b0;
      irwr_s      = 1'b0;
      pcwr_s      = 1'b0;
      rfwr_s      = 1'b0;
      illegal_s   = 1'b0;
      npc_s       = NPC_PLUS4;
      wdsel_s     = WD_ALU;
      case (state_r)
         S_FETCH: begin
            mem_req_s = 1'b1;
            if (mem_ack) begin
               irwr_s      = 1'b1;
               pcwr_s      = 1'b1;
               state_nxt_s = S_DCD;
            end else begin
               state_nxt_s = S_FETCH;
            end
         end
         S_DCD: begin
            // jump and illegal resolve here from the live IR, before anything is latched
            if (dec_class_s == C_J) begin
               pcwr_s      = 1'b1;
               npc_s       = NPC_JUMP;
               state_nxt_s = S_FETCH;
            end else if (dec_illegal_s) begin
               illegal_s   = 1'b1;
               state_nxt_s = S_FETCH;
            end else begin
               state_nxt_s = S_EXE;
            end
         end
         S_EXE: begin
            case (class_r)
               C_BEQ: begin
                  pcwr_s      = Zero;
                  npc_s       = NPC_BRANCH;
                  state_nxt_s = S_FETCH;
               end
               C_LW, C_SW: state_nxt_s = S_MEM;
               default:    state_nxt_s = S_WB;
            endcase
         end
         S_MEM: begin
            mem_req_s = 1'b1;
            dmwr_s    = (class_r == C_SW);
            if (mem_ack) begin
               state_nxt_s = (class_r == C_SW) ? S_FETCH : S_WB;
            end else begin
               state_nxt_s = S_MEM;
            end
         end
         S_WB: begin
            rfwr_s      = 1'b1;
            wdsel_s     = (class_r == C_LW) ? WD_MEM : WD_ALU;
            state_nxt_s = S_FETCH;
         end
         default: state_nxt_s = S_FETCH;
      endcase
   end

   assign mem_req = mem_req_s & ~rst;
   assign DMWr    = dmwr_s    & ~rst;
   assign IRWr    = irwr_s    & ~rst;
   assign PCWr    = pcwr_s    & ~rst;
   assign RFWr    = rfwr_s    & ~rst;
   assign illegal = illegal_s & ~rst;
   assign NPCOp   = rst ? NPC_PLUS4 : npc_s;
   assign WDSel   = rst ? WD_ALU : wdsel_s;
   assign ExtOp   = ext_r;
   assign ALUOp   = alu_r;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed per-cycle vector table for mc_ctrl_fsm plus a hand-written lw wait-state sequence.
module tb_mc_ctrl_fsm;
   import mc_ctrl_fsm_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic [OP_W-1:0]    Op;
   logic [FUNCT_W-1:0] Funct;
   logic               Zero;
   logic               mem_ack;
   logic               mem_req, DMWr, IRWr, PCWr, RFWr, illegal;
   logic [NPCOP_W-1:0] NPCOp;
   logic [WDSEL_W-1:0] WDSel;
   logic [EXTOP_W-1:0] ExtOp;
   logic [ALUOP_W-1:0] ALUOp;

   int checks = 0;
   int errors = 0;

   // {mem_req, IRWr, PCWr, NPCOp, RFWr, WDSel, DMWr, ExtOp, ALUOp, illegal}
   typedef struct packed {
      logic        r;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        z;
      logic        ack;
      logic [13:0] exp;
   } vec_t;

   vec_t tv[$];

   mc_ctrl_fsm dut (
      .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ack(mem_ack),
      .mem_req(mem_req), .DMWr(DMWr), .IRWr(IRWr), .PCWr(PCWr), .NPCOp(NPCOp),
      .RFWr(RFWr), .WDSel(WDSel), .ExtOp(ExtOp), .ALUOp(ALUOp), .illegal(illegal)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic a, input logic m, input logic ir,
                               input logic pc, input logic [1:0] npc, input logic rf,
                               input logic wd, input logic dm, input logic [1:0] ext,
                               input logic [2:0] alu, input logic il);
      vec_t v;
      v.r   = r;
      v.op  = op;
      v.fn  = fn;
      v.z   = z;
      v.ack = a;
      v.exp = {m, ir, pc, npc, rf, wd, dm, ext, alu, il};
      return v;
   endfunction

   initial begin
      logic [13:0] act;
      int          rf_cyc;
      int          req_cnt;
      logic        wd_seen;

      // reset held 3 cycles with ack pending, then ori
      for (int i = 0; i < 3; i++)
         tv.push_back(mk(1'b1, OP_ORI, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_ADD, 1'b0));
      tv.push_back(mk(1'b0, OP_ORI, 6'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_ADD, 1'b0));
      tv.push_back(mk(1'b0, OP_ORI, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_ADD, 1'b0));
      tv.push_back(mk(1'b0, OP_ORI, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_UNSIGN, ALU_OR, 1'b0));
      tv.push_back(mk(1'b0, OP_ORI, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NPC_PLUS4, 1'b1, WD_ALU, 1'b0, EXT_UNSIGN, ALU_OR, 1'b0));
      // lw with 3 wait cycles in MEM
      tv.push_back(mk(1'b0, OP_LW, 6'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_UNSIGN, ALU_OR, 1'b0));
      tv.push_back(mk(1'b0, OP_LW, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_UNSIGN, ALU_OR, 1'b0));
      tv.push_back(mk(1'b0, OP_LW, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_ADD, 1'b0));
      for (int i = 0; i < 3; i++)
         tv.push_back(mk(1'b0, OP_LW, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_ADD, 1'b0));
      tv.push_back(mk(1'b0, OP_LW, 6'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_ADD, 1'b0));
      tv.push_back(mk(1'b0, OP_LW, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NPC_PLUS4, 1'b1, WD_MEM, 1'b0, EXT_SIGNED, ALU_ADD, 1'b0));
      // beq taken, then not taken
      tv.push_back(mk(1'b0, OP_BEQ, 6'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_ADD, 1'b0));
      tv.push_back(mk(1'b0, OP_BEQ, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_ADD, 1'b0));
      tv.push_back(mk(1'b0, OP_BEQ, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, NPC_BRANCH, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_SUB, 1'b0));
      tv.push_back(mk(1'b0, OP_BEQ, 6'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_SUB, 1'b0));
      tv.push_back(mk(1'b0, OP_BEQ, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_SUB, 1'b0));
      tv.push_back(mk(1'b0, OP_BEQ, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NPC_BRANCH, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_SUB, 1'b0));
      // lui, then an illegal opcode
      tv.push_back(mk(1'b0, OP_LUI, 6'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_SUB, 1'b0));
      tv.push_back(mk(1'b0, OP_LUI, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_SUB, 1'b0));
      tv.push_back(mk(1'b0, OP_LUI, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_HIGH16, ALU_LUI, 1'b0));
      tv.push_back(mk(1'b0, OP_LUI, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NPC_PLUS4, 1'b1, WD_ALU, 1'b0, EXT_HIGH16, ALU_LUI, 1'b0));
      tv.push_back(mk(1'b0, 6'h3F, 6'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_HIGH16, ALU_LUI, 1'b0));
      tv.push_back(mk(1'b0, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_HIGH16, ALU_LUI, 1'b1));
      tv.push_back(mk(1'b0, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_ADD, 1'b0));
      // sw aborted by reset in MEM with ack
      tv.push_back(mk(1'b0, OP_SW, 6'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_ADD, 1'b0));
      tv.push_back(mk(1'b0, OP_SW, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_ADD, 1'b0));
      tv.push_back(mk(1'b0, OP_SW, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_ADD, 1'b0));
      tv.push_back(mk(1'b0, OP_SW, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NPC_PLUS4, 1'b0, WD_ALU, 1'b1, EXT_SIGNED, ALU_ADD, 1'b0));
      tv.push_back(mk(1'b1, OP_SW, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_ADD, 1'b0));
      tv.push_back(mk(1'b0, OP_SW, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_ADD, 1'b0));
      // j, then R-type subu
      tv.push_back(mk(1'b0, OP_J, 6'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_ADD, 1'b0));
      tv.push_back(mk(1'b0, OP_J, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NPC_JUMP, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_ADD, 1'b0));
      tv.push_back(mk(1'b0, OP_RTYPE, FN_SUBU, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_ADD, 1'b0));
      tv.push_back(mk(1'b0, OP_RTYPE, FN_SUBU, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_ADD, 1'b0));
      tv.push_back(mk(1'b0, OP_RTYPE, FN_SUBU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_ADD, 1'b0));
      tv.push_back(mk(1'b0, OP_RTYPE, FN_SUBU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NPC_PLUS4, 1'b0, WD_ALU, 1'b0, EXT_SIGNED, ALU_SUB, 1'b0));
      tv.push_back(mk(1'b0, OP_RTYPE, FN_SUBU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NPC_PLUS4, 1'b1, WD_ALU, 1'b0, EXT_SIGNED, ALU_SUB, 1'b0));

      rst = 1'b1; Op = OP_ORI; Funct = 6'h00; Zero = 1'b0; mem_ack = 1'b1;
      @(posedge clk);

      for (int i = 0; i < tv.size(); i++) begin
         @(negedge clk);
         rst = tv[i].r; Op = tv[i].op; Funct = tv[i].fn; Zero = tv[i].z; mem_ack = tv[i].ack;
         #1;
         act = {mem_req, IRWr, PCWr, NPCOp, RFWr, WDSel, DMWr, ExtOp, ALUOp, illegal};
         checks++;
         if (act !== tv[i].exp) begin
            errors++;
            $display("FAIL vec%0d: got %b expected %b (mreq,ir,pc,npc2,rf,wd,dm,ext2,alu3,ill)",
                     i, act, tv[i].exp);
         end
      end

      // lw with two MEM wait cycles: RFWr expected on cycle 7, mem_req high 3 cycles after fetch
      rf_cyc = 0; req_cnt = 0; wd_seen = 1'b0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         rst = 1'b0; Op = OP_LW; Funct = 6'h00; Zero = 1'b0;
         mem_ack = (cyc == 1 || cyc == 6) ? 1'b1 : 1'b0;
         #1;
         if (cyc >= 2 && rf_cyc == 0 && mem_req) req_cnt++;
         if (RFWr && rf_cyc == 0) begin
            rf_cyc  = cyc;
            wd_seen = WDSel;
         end
      end
      checks++;
      if (rf_cyc != 7) begin
         errors++;
         $display("FAIL lw_wait_rfwr_cycle: got %0d expected 7", rf_cyc);
      end
      checks++;
      if (req_cnt != 3) begin
         errors++;
         $display("FAIL lw_wait_req_cycles: got %0d expected 3", req_cnt);
      end
      checks++;
      if (wd_seen !== WD_MEM) begin
         errors++;
         $display("FAIL lw_wait_wdsel: got %0d expected %0d", wd_seen, WD_MEM);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
